// File: rtl/shifter_arb_pkg.sv
// rtl/shifter_arb_pkg.sv - shared constants and types for the shifter arbiter
package shifter_arb_pkg;

    localparam logic MODE_SHL = 1'b0;
    localparam logic MODE_ROL = 1'b1;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/shifter_arbiter_if.sv
// rtl/shifter_arbiter_if.sv - request/result handshake bundle for the shifter arbiter
interface shifter_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_data;
    logic [AMT_W-1:0] req0_amt;
    logic             req0_mode;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_data;
    logic [AMT_W-1:0] req1_amt;
    logic             req1_mode;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_id;

    // requesters plus result consumer
    modport master (
        output req0_valid, req0_data, req0_amt, req0_mode,
        output req1_valid, req1_data, req1_amt, req1_mode,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_id,
        output out_ready
    );

    // arbiter side
    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_mode,
        input  req1_valid, req1_data, req1_amt, req1_mode,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_id,
        input  out_ready
    );
endinterface

// File: rtl/shift_rotate_unit.sv
// rtl/shift_rotate_unit.sv - combinational logical-shift-left / rotate-left unit
module shift_rotate_unit
    import shifter_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amt,
    input  logic             mode,
    output logic [WIDTH-1:0] result
);
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] wrap;
    logic [AMT_W:0]   back_amt;

    // amt=0 gives back_amt=WIDTH, so the wrapped part shifts out to zero
    assign back_amt = (AMT_W+1)'(WIDTH) - {1'b0, amt};
    assign shl      = data << amt;
    assign wrap     = data >> back_amt;

    // select zero-fill shift or rotate
    always_comb begin
        result = shl;
        if (mode == MODE_ROL) begin
            result = shl | wrap;
        end
    end
endmodule

// File: rtl/shifter_arbiter.sv
// rtl/shifter_arbiter.sv - round-robin sharing of one shift/rotate unit; SHIFT_STATS_EN adds grant counters
module shifter_arbiter
    import shifter_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    shifter_arbiter_if.slave     bus
`ifdef SHIFT_STATS_EN
    ,
    output logic [CNT_W-1:0]     grant_cnt0,
    output logic [CNT_W-1:0]     grant_cnt1
`endif
);
    slot_state_t      state_q;
    slot_state_t      state_d;
    logic             ptr_q;
    logic             slot_free;
    logic             grant0;
    logic             grant1;
    logic             acc0;
    logic             acc1;
    logic             accept;
    logic             acc_id;
    logic [WIDTH-1:0] op_data;
    logic [AMT_W-1:0] op_amt;
    logic             op_mode;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] out_data_q;
    logic             out_id_q;

    // the slot can take a new op when empty or being drained this cycle
    assign slot_free = (state_q == SLOT_EMPTY) || bus.out_ready;

    // a lone requester wins; on contention the pointer decides
    assign grant0 = bus.req0_valid && (!bus.req1_valid || ptr_q == REQ0);
    assign grant1 = bus.req1_valid && (!bus.req0_valid || ptr_q == REQ1);

    assign bus.req0_ready = grant0 && slot_free && !rst;
    assign bus.req1_ready = grant1 && slot_free && !rst;

    assign acc0   = bus.req0_valid && bus.req0_ready;
    assign acc1   = bus.req1_valid && bus.req1_ready;
    assign accept = acc0 || acc1;
    assign acc_id = acc1 ? REQ1 : REQ0;

    // route the granted requester's operands into the shared unit
    always_comb begin
        op_data = bus.req0_data;
        op_amt  = bus.req0_amt;
        op_mode = bus.req0_mode;
        if (grant1) begin
            op_data = bus.req1_data;
            op_amt  = bus.req1_amt;
            op_mode = bus.req1_mode;
        end
    end

    shift_rotate_unit #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_sru (
        .data   (op_data),
        .amt    (op_amt),
        .mode   (op_mode),
        .result (result)
    );

    // slot next state: fill on accept, empty on drain without refill
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
            SLOT_FULL:  if (bus.out_ready && !accept) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    // slot state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // result slot and round-robin pointer; both only move on an accept
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q <= '0;
            out_id_q   <= REQ0;
            ptr_q      <= REQ0;
        end else if (accept) begin
            out_data_q <= result;
            out_id_q   <= acc_id;
            ptr_q      <= ~acc_id;
        end
    end

    assign bus.out_valid = (state_q == SLOT_FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;

`ifdef SHIFT_STATS_EN
    // per-requester accept counters, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (acc0 && grant_cnt0 != {CNT_W{1'b1}}) grant_cnt0 <= grant_cnt0 + 1'b1;
            if (acc1 && grant_cnt1 != {CNT_W{1'b1}}) grant_cnt1 <= grant_cnt1 + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_shifter_arbiter.sv
// tb/tb_shifter_arbiter.sv - directed self-checking bench for shifter_arbiter
module tb_shifter_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

`ifdef SHIFT_STATS_EN
    logic [7:0] grant_cnt0;
    logic [7:0] grant_cnt1;
`endif

    shifter_arbiter_if #(.WIDTH(8), .AMT_W(3)) bus ();

    shifter_arbiter #(
        .WIDTH (8),
        .AMT_W (3),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef SHIFT_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic id);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, "_data"},  32'(bus.out_data),  32'(d));
        chk({tag, "_id"},    32'(bus.out_id),    32'(id));
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, "_r0"}, 32'(bus.req0_ready), 32'(r0));
        chk({tag, "_r1"}, 32'(bus.req1_ready), 32'(r1));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_data = 8'hC3; bus.req0_amt = 3'd1; bus.req0_mode = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_data = 8'hC3; bus.req1_amt = 3'd5; bus.req1_mode = 1'b1;
        bus.out_ready  = 1'b1;

        // reset held two cycles with both requesters valid
        @(negedge clk);
        @(negedge clk);
        chk_rdy("reset", 1'b0, 1'b0);
        chk_out("reset", 1'b0, 8'h00, 1'b0);

        // requester 0 alone: C3 << 1
        rst = 1'b0;
        bus.req1_valid = 1'b0;
        #1 chk_rdy("r0only", 1'b1, 1'b0);
        @(negedge clk);
        chk_out("r0only", 1'b1, 8'h86, 1'b0);
        bus.req0_valid = 1'b0;

        // requester 1 alone: C3 rol 5, then rol 0
        bus.req1_valid = 1'b1;
        #1 chk_rdy("r1only", 1'b0, 1'b1);
        @(negedge clk);
        chk_out("r1rol5", 1'b1, 8'h78, 1'b1);
        bus.req1_amt = 3'd0;
        @(negedge clk);
        chk_out("r1rol0", 1'b1, 8'hC3, 1'b1);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        // both valid continuously after reset: 01<<1=02 (id0), 01 rol 2=04 (id1)
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_data = 8'h01; bus.req0_amt = 3'd1; bus.req0_mode = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h01; bus.req1_amt = 3'd2; bus.req1_mode = 1'b1;
        #1 chk_rdy("rr_n0", 1'b1, 1'b0);
        chk("rr_n0_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk_out("rr_n1", 1'b1, 8'h02, 1'b0);
        chk_rdy("rr_n1", 1'b0, 1'b1);
        @(negedge clk);
        chk_out("rr_n2", 1'b1, 8'h04, 1'b1);
        chk_rdy("rr_n2", 1'b1, 1'b0);
        @(negedge clk);
        chk_out("rr_n3", 1'b1, 8'h02, 1'b0);
        chk_rdy("rr_n3", 1'b0, 1'b1);
        @(negedge clk);
        chk_out("rr_n4", 1'b1, 8'h04, 1'b1);

        // backpressure for three cycles: slot holds id1/04, nobody accepted
        bus.out_ready = 1'b0;
        #1 chk_rdy("bp0", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_out("bp_hold", 1'b1, 8'h04, 1'b1);
            chk_rdy("bp_hold", 1'b0, 1'b0);
        end

        // release: drain and refill in the same cycle, requester 0 next
        bus.out_ready = 1'b1;
        #1 chk_rdy("bp_rel", 1'b1, 1'b0);
        @(negedge clk);
        chk_out("bp_refill", 1'b1, 8'h02, 1'b0);

        // reset mid-op with slot full and both valid; pointer was at requester 1
        rst = 1'b1;
        #1 chk_rdy("midrst", 1'b0, 1'b0);
        @(negedge clk);
        chk_out("midrst", 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        #1 chk_rdy("post_rst", 1'b1, 1'b0);
        @(negedge clk);
        chk_out("post_rst", 1'b1, 8'h02, 1'b0);

`ifdef SHIFT_STATS_EN
        // saturating counter: 300 requester-0 accepts
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 300; i++) @(negedge clk);
        chk("cnt0_sat", 32'(grant_cnt0), 32'hFF);
        chk("cnt1_idle", 32'(grant_cnt1), 32'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("cnt0_rst", 32'(grant_cnt0), 32'h00);
        chk("cnt1_rst", 32'(grant_cnt1), 32'h00);
        rst = 1'b0;
`endif

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
